// File: rtl/dds_cmd_frame_parser_if.sv
// Byte-stream input and storage/parameter handshake bundle for dds_cmd_frame_parser.
// master = parser side, slave = UART receiver plus storage engine side.
interface dds_cmd_frame_parser_if #(
   parameter int GW = 2
);
   logic          Rx_Done;
   logic [7:0]    Rx_Data;
   logic          Frame_Error;
   logic          Wr_Req;
   logic          Wr_Ack;
   logic [GW-1:0] Wr_Group;
   logic [55:0]   Wr_Data;
   logic          Rd_Req;
   logic          Rd_Ack;
   logic [GW-1:0] Rd_Group;
   logic [7:0]    Wave_Sel;
   logic [31:0]   Fword;
   logic [11:0]   Pword;
   logic          Param_Valid;
   logic [GW-1:0] Group_Sel;
   logic          Cmd_Err;
   logic          Busy;

   modport master (
      input  Rx_Done, Rx_Data, Frame_Error, Wr_Ack, Rd_Ack,
      output Wr_Req, Wr_Group, Wr_Data, Rd_Req, Rd_Group,
             Wave_Sel, Fword, Pword, Param_Valid, Group_Sel, Cmd_Err, Busy
   );

   modport slave (
      output Rx_Done, Rx_Data, Frame_Error, Wr_Ack, Rd_Ack,
      input  Wr_Req, Wr_Group, Wr_Data, Rd_Req, Rd_Group,
             Wave_Sel, Fword, Pword, Param_Valid, Group_Sel, Cmd_Err, Busy
   );
endinterface

// File: rtl/dds_cmd_frame_parser.sv
// UART command parser: group select, 7-byte write payload with inter-byte timeout, read request.
// Define DDS_CMD_CHECKSUM_EN to require an eighth XOR checksum byte on every write payload.
module dds_cmd_frame_parser #(
   parameter int NUM_GROUPS  = 4,
   parameter int TIMEOUT_CYC = 500000
) (
   input  logic                   Clk,
   input  logic                   Reset_n,
   dds_cmd_frame_parser_if.master bus
);
   localparam int GW = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;
   localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
`ifdef DDS_CMD_CHECKSUM_EN
   localparam logic [2:0] LAST_IDX = 3'd7;
   localparam int         PW       = 56;
`else
   localparam logic [2:0] LAST_IDX = 3'd6;
   localparam int         PW       = 48;
`endif

   typedef enum logic [1:0] {IDLE = 2'd0, PAYLOAD = 2'd1, WR_REQ = 2'd2, RD_REQ = 2'd3} state_t;

   state_t          state_q, state_d;
   logic [2:0]      cnt_q, cnt_d;
   logic [TW-1:0]   tmr_q, tmr_d;
   logic [GW-1:0]   group_sel_q, group_sel_d;
   logic            wr_req_q, wr_req_d;
   logic [GW-1:0]   wr_group_q, wr_group_d;
   logic [55:0]     wr_data_q, wr_data_d;
   logic            rd_req_q, rd_req_d;
   logic [GW-1:0]   rd_group_q, rd_group_d;
   logic [7:0]      wave_sel_q, wave_sel_d;
   logic [31:0]     fword_q, fword_d;
   logic [11:0]     pword_q, pword_d;
   logic            param_valid_q, param_valid_d;
   logic            cmd_err_q, cmd_err_d;
   logic            err_pend_q, err_pend_d;
   logic            busy_q, busy_d;
   logic [PW-1:0]   pay_q, pay_d;
`ifdef DDS_CMD_CHECKSUM_EN
   logic [7:0]      xor_q, xor_d;
`endif
   logic            err_now;
   logic [7:0]      rx_byte;
   logic [1:0]      rst_sync_q;
   logic            rst_n_core;

   // Reset asserts immediately, releases two clock edges after Reset_n rises.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) rst_sync_q <= 2'b00;
      else          rst_sync_q <= {rst_sync_q[0], 1'b1};
   end
   assign rst_n_core = rst_sync_q[1];

   assign rx_byte = bus.Rx_Data;

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      tmr_d         = tmr_q;
      group_sel_d   = group_sel_q;
      wr_req_d      = wr_req_q;
      wr_group_d    = wr_group_q;
      wr_data_d     = wr_data_q;
      rd_req_d      = rd_req_q;
      rd_group_d    = rd_group_q;
      wave_sel_d    = wave_sel_q;
      fword_d       = fword_q;
      pword_d       = pword_q;
      pay_d         = pay_q;
`ifdef DDS_CMD_CHECKSUM_EN
      xor_d         = xor_q;
`endif
      param_valid_d = 1'b0;
      err_now       = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.Rx_Done) begin
               if (bus.Frame_Error) begin
                  err_now = 1'b1;
               end else if (rx_byte[7:4] == 4'h3 && {1'b0, rx_byte[3:0]} < 5'(NUM_GROUPS)) begin
                  group_sel_d = rx_byte[GW-1:0];
               end else if (rx_byte == 8'h20) begin
                  state_d = PAYLOAD;
                  cnt_d   = 3'd0;
                  tmr_d   = '0;
`ifdef DDS_CMD_CHECKSUM_EN
                  xor_d   = 8'h00;
`endif
               end else if (rx_byte == 8'h10) begin
                  state_d    = RD_REQ;
                  rd_req_d   = 1'b1;
                  rd_group_d = group_sel_q;
               end else begin
                  err_now = 1'b1;
               end
            end
         end
         PAYLOAD: begin
            if (bus.Rx_Done) begin
               tmr_d = '0;
               if (bus.Frame_Error) begin
                  err_now = 1'b1;
                  state_d = IDLE;
               end else if (cnt_q == LAST_IDX) begin
`ifdef DDS_CMD_CHECKSUM_EN
                  if (rx_byte == xor_q) begin
                     state_d    = WR_REQ;
                     wr_req_d   = 1'b1;
                     wr_group_d = group_sel_q;
                     wr_data_d  = pay_q;
                  end else begin
                     err_now = 1'b1;
                     state_d = IDLE;
                  end
`else
                  state_d    = WR_REQ;
                  wr_req_d   = 1'b1;
                  wr_group_d = group_sel_q;
                  wr_data_d  = {pay_q, rx_byte};
`endif
               end else begin
                  pay_d = {pay_q[PW-9:0], rx_byte};
                  cnt_d = cnt_q + 3'd1;
`ifdef DDS_CMD_CHECKSUM_EN
                  xor_d = xor_q ^ rx_byte;
`endif
               end
            end else if (tmr_q == TW'(TIMEOUT_CYC - 1)) begin
               err_now = 1'b1;
               state_d = IDLE;
               tmr_d   = '0;
            end else begin
               tmr_d = tmr_q + 1'b1;
            end
         end
         WR_REQ: begin
            if (bus.Rx_Done) err_now = 1'b1;
            if (bus.Wr_Ack) begin
               wr_req_d      = 1'b0;
               wave_sel_d    = wr_data_q[55:48];
               fword_d       = wr_data_q[47:16];
               pword_d       = wr_data_q[15:4];
               param_valid_d = 1'b1;
               state_d       = IDLE;
            end
         end
         RD_REQ: begin
            if (bus.Rx_Done) err_now = 1'b1;
            if (bus.Rd_Ack) begin
               rd_req_d = 1'b0;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // An error coinciding with a commit is reported on the following cycle instead.
      cmd_err_d  = (err_now | err_pend_q) & ~param_valid_d;
      err_pend_d = (err_now | err_pend_q) & param_valid_d;
      busy_d     = (state_d != IDLE);
   end

   always_ff @(posedge Clk or negedge rst_n_core) begin
      if (!rst_n_core) begin
         state_q       <= IDLE;
         cnt_q         <= 3'd0;
         tmr_q         <= '0;
         group_sel_q   <= '0;
         wr_req_q      <= 1'b0;
         wr_group_q    <= '0;
         wr_data_q     <= '0;
         rd_req_q      <= 1'b0;
         rd_group_q    <= '0;
         wave_sel_q    <= '0;
         fword_q       <= '0;
         pword_q       <= '0;
         param_valid_q <= 1'b0;
         cmd_err_q     <= 1'b0;
         err_pend_q    <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         tmr_q         <= tmr_d;
         group_sel_q   <= group_sel_d;
         wr_req_q      <= wr_req_d;
         wr_group_q    <= wr_group_d;
         wr_data_q     <= wr_data_d;
         rd_req_q      <= rd_req_d;
         rd_group_q    <= rd_group_d;
         wave_sel_q    <= wave_sel_d;
         fword_q       <= fword_d;
         pword_q       <= pword_d;
         param_valid_q <= param_valid_d;
         cmd_err_q     <= cmd_err_d;
         err_pend_q    <= err_pend_d;
         busy_q        <= busy_d;
      end
   end

   // Payload assembly bytes are fully rewritten before use, so they need no reset.
   always_ff @(posedge Clk) begin
      pay_q <= pay_d;
`ifdef DDS_CMD_CHECKSUM_EN
      xor_q <= xor_d;
`endif
   end

   assign bus.Wr_Req      = wr_req_q;
   assign bus.Wr_Group    = wr_group_q;
   assign bus.Wr_Data     = wr_data_q;
   assign bus.Rd_Req      = rd_req_q;
   assign bus.Rd_Group    = rd_group_q;
   assign bus.Wave_Sel    = wave_sel_q;
   assign bus.Fword       = fword_q;
   assign bus.Pword       = pword_q;
   assign bus.Param_Valid = param_valid_q;
   assign bus.Group_Sel   = group_sel_q;
   assign bus.Cmd_Err     = cmd_err_q;
   assign bus.Busy        = busy_q;
endmodule

// File: tb/tb_dds_cmd_frame_parser.sv
// Scoreboard bench for dds_cmd_frame_parser (NUM_GROUPS=4, short timeout); honours DDS_CMD_CHECKSUM_EN.
module tb_dds_cmd_frame_parser;
   localparam int NG = 4;
   localparam int TO = 20;

   typedef struct packed {
      logic [1:0]  grp;
      logic [55:0] data;
   } wr_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   dds_cmd_frame_parser_if #(.GW(2)) bus ();
   dds_cmd_frame_parser #(.NUM_GROUPS(NG), .TIMEOUT_CYC(TO)) dut (
      .Clk(clk), .Reset_n(rst_n), .bus(bus)
   );

   int tests_run = 0;
   int tests_failed = 0;
   int cnt_err = 0, cnt_pv = 0, cnt_wr = 0, cnt_rd = 0, cnt_both = 0;
   wr_t        wr_q[$];
   logic [1:0] rd_q[$];
   logic [7:0]  m_wave;
   logic [31:0] m_fword;
   logic [11:0] m_pword;

   always @(negedge clk) begin
      if (bus.Cmd_Err) cnt_err++;
      if (bus.Param_Valid) cnt_pv++;
      if (bus.Wr_Req) cnt_wr++;
      if (bus.Rd_Req) cnt_rd++;
      if (bus.Cmd_Err && bus.Param_Valid) cnt_both++;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic fe);
      bus.Rx_Done = 1'b1;
      bus.Rx_Data = b;
      bus.Frame_Error = fe;
      tick();
      bus.Rx_Done = 1'b0;
      bus.Frame_Error = 1'b0;
   endtask

   task automatic send_payload(input logic [55:0] d);
      logic [7:0] x;
      x = 8'h00;
      send_byte(8'h20, 1'b0);
      for (int i = 0; i < 7; i++) begin
         x = x ^ d[55-8*i -: 8];
         send_byte(d[55-8*i -: 8], 1'b0);
      end
`ifdef DDS_CMD_CHECKSUM_EN
      send_byte(x, 1'b0);
`endif
   endtask

   // Bounded wait for Wr_Req, then ack after dly cycles; reports what was seen.
   task automatic run_commit(input int dly, output bit seen, output logic [1:0] g,
                             output logic [55:0] dat, output bit pv);
      seen = 1'b0;
      pv = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         if (bus.Wr_Req) seen = 1'b1;
         else tick();
      end
      repeat (dly) tick();
      g = bus.Wr_Group;
      dat = bus.Wr_Data;
      if (seen) begin
         bus.Wr_Ack = 1'b1;
         tick();
         bus.Wr_Ack = 1'b0;
         pv = bus.Param_Valid && !bus.Wr_Req;
      end
   endtask

   task automatic test_reset();
      bus.Rx_Done = 0; bus.Rx_Data = 0; bus.Frame_Error = 0; bus.Wr_Ack = 0; bus.Rd_Ack = 0;
      rst_n = 1'b0;
      repeat (3) tick();
      tests_run++;
      if ({bus.Wr_Req, bus.Rd_Req, bus.Busy, bus.Cmd_Err, bus.Param_Valid} !== 5'b0) begin
         tests_failed++;
         $display("FAIL reset_ctrl: got %b want 00000", {bus.Wr_Req, bus.Rd_Req, bus.Busy, bus.Cmd_Err, bus.Param_Valid});
      end
      rst_n = 1'b1;
      repeat (4) tick();
      tests_run++;
      if ({bus.Wr_Data, bus.Fword, bus.Pword, bus.Wave_Sel, bus.Group_Sel, bus.Wr_Group, bus.Rd_Group, bus.Busy} !== '0) begin
         tests_failed++;
         $display("FAIL reset_data: Wr_Data=%h Fword=%h Pword=%h Group_Sel=%0d Busy=%b want all 0",
                  bus.Wr_Data, bus.Fword, bus.Pword, bus.Group_Sel, bus.Busy);
      end
      m_wave = 0; m_fword = 0; m_pword = 0;
   endtask

   task automatic check_commit(input string nm, input int dly);
      bit seen, pv;
      logic [1:0] g;
      logic [55:0] dat;
      wr_t e;
      run_commit(dly, seen, g, dat, pv);
      e = (wr_q.size() != 0) ? wr_q.pop_front() : '0;
      tests_run++;
      if (!seen || !pv || g !== e.grp || dat !== e.data) begin
         tests_failed++;
         $display("FAIL %s_commit: req=%b pv=%b grp=%0d data=%h want req=1 pv=1 grp=%0d data=%h",
                  nm, seen, pv, g, dat, e.grp, e.data);
      end
      m_wave = e.data[55:48]; m_fword = e.data[47:16]; m_pword = e.data[15:4];
      tests_run++;
      if (bus.Wave_Sel !== m_wave || bus.Fword !== m_fword || bus.Pword !== m_pword) begin
         tests_failed++;
         $display("FAIL %s_params: wave=%h fword=%h pword=%h want %h %h %h",
                  nm, bus.Wave_Sel, bus.Fword, bus.Pword, m_wave, m_fword, m_pword);
      end
   endtask

   task automatic test_write_basic();
      int pv0;
      send_byte(8'h31, 1'b0);
      tests_run++;
      if (bus.Group_Sel !== 2'd1) begin tests_failed++; $display("FAIL t1_group: got %0d want 1", bus.Group_Sel); end
      wr_q.push_back({2'd1, 56'h020506070845_6A});
      pv0 = cnt_pv;
      send_payload(56'h020506070845_6A);
      tests_run++;
      if (bus.Wr_Req !== 1'b1 || bus.Busy !== 1'b1) begin
         tests_failed++; $display("FAIL t1_latency: Wr_Req=%b Busy=%b want 1 1", bus.Wr_Req, bus.Busy);
      end
      check_commit("t1", 3);
      tests_run++;
      if (bus.Wave_Sel !== 8'h02 || bus.Fword !== 32'h05060708 || bus.Pword !== 12'h456) begin
         tests_failed++;
         $display("FAIL t1_fields: wave=%h fword=%h pword=%h want 02 05060708 456", bus.Wave_Sel, bus.Fword, bus.Pword);
      end
      tick();
      tests_run++;
      if (cnt_pv - pv0 !== 1 || bus.Busy !== 1'b0) begin
         tests_failed++; $display("FAIL t1_pv_count: pulses=%0d busy=%b want 1 0", cnt_pv - pv0, bus.Busy);
      end
   endtask

   task automatic test_read();
      int rd0, e0;
      logic [1:0] eg;
      send_byte(8'h33, 1'b0);
      bus.Rd_Ack = 1'b1;
      rd_q.push_back(2'd3);
      rd0 = cnt_rd;
      send_byte(8'h10, 1'b0);
      eg = (rd_q.size() != 0) ? rd_q.pop_front() : 2'd0;
      tests_run++;
      if (bus.Rd_Req !== 1'b1 || bus.Rd_Group !== eg) begin
         tests_failed++; $display("FAIL t2_rd_req: req=%b grp=%0d want 1 %0d", bus.Rd_Req, bus.Rd_Group, eg);
      end
      tick();
      bus.Rd_Ack = 1'b0;
      tests_run++;
      if (bus.Rd_Req !== 1'b0 || bus.Busy !== 1'b0 || cnt_rd - rd0 !== 1) begin
         tests_failed++;
         $display("FAIL t2_rd_done: req=%b busy=%b cycles=%0d want 0 0 1", bus.Rd_Req, bus.Busy, cnt_rd - rd0);
      end
      e0 = cnt_err;
      send_byte(8'h34, 1'b0);
      tests_run++;
      if (bus.Cmd_Err !== 1'b1 || bus.Group_Sel !== 2'd3) begin
         tests_failed++; $display("FAIL t2_bad_group: err=%b grp=%0d want 1 3", bus.Cmd_Err, bus.Group_Sel);
      end
      tick();
      tests_run++;
      if (cnt_err - e0 !== 1) begin tests_failed++; $display("FAIL t2_err_count: got %0d want 1", cnt_err - e0); end
   endtask

   task automatic test_timeout();
      int e0, w0;
      e0 = cnt_err; w0 = cnt_wr;
      send_byte(8'h20, 1'b0);
      send_byte(8'hA1, 1'b0);
      send_byte(8'hA2, 1'b0);
      send_byte(8'hA3, 1'b0);
      repeat (TO - 1) tick();
      tests_run++;
      if (bus.Busy !== 1'b1 || cnt_err != e0) begin
         tests_failed++; $display("FAIL t3_before_timeout: busy=%b errs=%0d want 1 0", bus.Busy, cnt_err - e0);
      end
      tick();
      tests_run++;
      if (bus.Busy !== 1'b0 || bus.Cmd_Err !== 1'b1) begin
         tests_failed++; $display("FAIL t3_timeout: busy=%b err=%b want 0 1", bus.Busy, bus.Cmd_Err);
      end
      repeat (3) tick();
      tests_run++;
      if (cnt_err - e0 !== 1 || cnt_wr != w0) begin
         tests_failed++; $display("FAIL t3_counts: errs=%0d wr_cycles=%0d want 1 0", cnt_err - e0, cnt_wr - w0);
      end
      wr_q.push_back({2'd3, 56'h11223344556677});
      send_payload(56'h11223344556677);
      check_commit("t3", 1);
   endtask

   task automatic test_frame_error();
      int w0;
      logic [31:0] f0;
      w0 = cnt_wr; f0 = m_fword;
      send_byte(8'h20, 1'b0);
      send_byte(8'h12, 1'b0);
      send_byte(8'h34, 1'b0);
      send_byte(8'h56, 1'b1);
      tests_run++;
      if (bus.Cmd_Err !== 1'b1 || bus.Busy !== 1'b0) begin
         tests_failed++; $display("FAIL t4_abort: err=%b busy=%b want 1 0", bus.Cmd_Err, bus.Busy);
      end
      repeat (5) tick();
      tests_run++;
      if (cnt_wr != w0 || bus.Fword !== f0) begin
         tests_failed++; $display("FAIL t4_no_write: wr_cycles=%0d fword=%h want 0 %h", cnt_wr - w0, bus.Fword, f0);
      end
   endtask

   task automatic test_raw_payload();
      wr_q.push_back({2'd3, 56'h20103031332010});
      send_payload(56'h20103031332010);
      send_byte(8'h31, 1'b0);
      tests_run++;
      if (bus.Cmd_Err !== 1'b1 || bus.Wr_Req !== 1'b1 || bus.Wr_Data !== 56'h20103031332010 || bus.Group_Sel !== 2'd3) begin
         tests_failed++;
         $display("FAIL t5_byte_in_wr: err=%b req=%b data=%h grp=%0d want 1 1 20103031332010 3",
                  bus.Cmd_Err, bus.Wr_Req, bus.Wr_Data, bus.Group_Sel);
      end
      check_commit("t5", 0);
      tests_run++;
      if (bus.Fword !== 32'h10303133 || bus.Pword !== 12'h201) begin
         tests_failed++; $display("FAIL t5_fields: fword=%h pword=%h want 10303133 201", bus.Fword, bus.Pword);
      end
   endtask

   task automatic test_back_to_back();
      wr_t e;
      wr_q.push_back({2'd3, 56'hCAFEBABE123456});
      send_payload(56'hCAFEBABE123456);
      bus.Rx_Done = 1'b1; bus.Rx_Data = 8'h55; bus.Wr_Ack = 1'b1;
      tick();
      bus.Rx_Done = 1'b0; bus.Wr_Ack = 1'b0;
      e = (wr_q.size() != 0) ? wr_q.pop_front() : '0;
      tests_run++;
      if (bus.Param_Valid !== 1'b1 || bus.Cmd_Err !== 1'b0 || bus.Fword !== e.data[47:16]) begin
         tests_failed++;
         $display("FAIL b2b_commit: pv=%b err=%b fword=%h want 1 0 %h", bus.Param_Valid, bus.Cmd_Err, bus.Fword, e.data[47:16]);
      end
      tick();
      tests_run++;
      if (bus.Cmd_Err !== 1'b1 || bus.Param_Valid !== 1'b0) begin
         tests_failed++; $display("FAIL b2b_err_deferred: err=%b pv=%b want 1 0", bus.Cmd_Err, bus.Param_Valid);
      end
      wr_q.push_back({2'd3, 56'h0F0E0D0C0B0A09});
      send_payload(56'h0F0E0D0C0B0A09);
      check_commit("b2b", 0);
   endtask

   task automatic test_async_reset();
      send_byte(8'h32, 1'b0);
      send_byte(8'h20, 1'b0);
      send_byte(8'h77, 1'b0);
      rst_n = 1'b0;
      #1;
      tests_run++;
      if (bus.Busy !== 1'b0 || bus.Group_Sel !== 2'd0 || bus.Fword !== 32'h0 || bus.Wave_Sel !== 8'h0) begin
         tests_failed++;
         $display("FAIL t6_rst_payload: busy=%b grp=%0d fword=%h wave=%h want 0", bus.Busy, bus.Group_Sel, bus.Fword, bus.Wave_Sel);
      end
      repeat (2) tick();
      rst_n = 1'b1;
      repeat (4) tick();
      m_wave = 0; m_fword = 0; m_pword = 0;
      send_payload(56'h99887766554433);
      tests_run++;
      if (bus.Wr_Req !== 1'b1 || bus.Wr_Group !== 2'd0) begin
         tests_failed++; $display("FAIL t6_req_before_rst: req=%b grp=%0d want 1 0", bus.Wr_Req, bus.Wr_Group);
      end
      rst_n = 1'b0;
      #1;
      tests_run++;
      if (bus.Wr_Req !== 1'b0 || bus.Wr_Data !== 56'h0 || bus.Busy !== 1'b0) begin
         tests_failed++; $display("FAIL t6_rst_wrreq: req=%b data=%h busy=%b want 0 0 0", bus.Wr_Req, bus.Wr_Data, bus.Busy);
      end
      repeat (2) tick();
      rst_n = 1'b1;
      repeat (4) tick();
`ifdef DDS_CMD_CHECKSUM_EN
      begin
         logic [55:0] d;
         logic [7:0] x;
         int w0;
         d = 56'h0102030405060F;
         x = 8'h00;
         for (int i = 0; i < 7; i++) x = x ^ d[55-8*i -: 8];
         w0 = cnt_wr;
         send_byte(8'h20, 1'b0);
         for (int i = 0; i < 7; i++) send_byte(d[55-8*i -: 8], 1'b0);
         send_byte(x ^ 8'hFF, 1'b0);
         tests_run++;
         if (bus.Cmd_Err !== 1'b1 || bus.Busy !== 1'b0 || bus.Wr_Req !== 1'b0) begin
            tests_failed++; $display("FAIL t6_bad_xor: err=%b busy=%b req=%b want 1 0 0", bus.Cmd_Err, bus.Busy, bus.Wr_Req);
         end
         tick();
         tests_run++;
         if (cnt_wr != w0) begin tests_failed++; $display("FAIL t6_bad_xor_wr: wr_cycles=%0d want 0", cnt_wr - w0); end
         wr_q.push_back({2'd0, d});
         send_payload(d);
         check_commit("t6_xor", 2);
      end
`else
      wr_q.push_back({2'd0, 56'h0102030405060F});
      send_payload(56'h0102030405060F);
      check_commit("t6_after_rst", 2);
`endif
   endtask

   initial begin
      test_reset();
      test_write_basic();
      test_read();
      test_timeout();
      test_frame_error();
      test_raw_payload();
      test_back_to_back();
      test_async_reset();
      repeat (3) tick();
      tests_run++;
      if (cnt_both != 0 || wr_q.size() != 0 || rd_q.size() != 0) begin
         tests_failed++;
         $display("FAIL final_state: err_and_pv_cycles=%0d pending_wr=%0d pending_rd=%0d want 0 0 0",
                  cnt_both, wr_q.size(), rd_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
